// File: rtl/mac_lane_pkg.sv
// mac_lane_pkg
//   Shared types and helpers for the multi-lane MAC datapath.
//   - state_t   : top-level job FSM states
//   - CNT_W_DEF : beat counter width for the default maximum job length
//   - sat_shift : arithmetic right shift, optional ReLU and symmetric clip of
//                 one accumulator value to an io_w-bit signed sample;
//                 returns {sat, data} where data is sign-extended to CALC_W
package mac_lane_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  localparam int unsigned MAX_ACC_LEN_DEF = 1600;
  localparam int unsigned CNT_W_DEF       = $clog2(MAX_ACC_LEN_DEF + 1);

  // Working width for post-processing; wide enough for any supported
  // accumulator so the shift and the clip compare never overflow.
  localparam int unsigned CALC_W = 64;

  typedef struct packed {
    logic                     sat;
    logic signed [CALC_W-1:0] data;
  } sat_res_t;

  function automatic sat_res_t sat_shift(
    input logic signed [CALC_W-1:0] acc,
    input logic        [4:0]        shift,
    input logic                     relu,
    input int unsigned              io_w
  );
    logic signed [CALC_W-1:0] s;
    logic signed [CALC_W-1:0] one;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    sat_res_t                 res;
    one      = 1;
    hi       = (one <<< (io_w - 1)) - one;
    lo       = -(one <<< (io_w - 1));
    s        = acc >>> shift;
    res.sat  = 1'b0;
    res.data = s;
    // ReLU happens before clipping, so a clamped negative never flags sat.
    if (relu && (s < 0)) begin
      res.data = '0;
    end else if (s > hi) begin
      res.sat  = 1'b1;
      res.data = hi;
    end else if (s < lo) begin
      res.sat  = 1'b1;
      res.data = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane
//   One output-channel lane: signed product of the broadcast activation and
//   this lane's weight, added either to the running accumulator or, on the
//   first beat of a job, to the optional partial-sum seed.
//   Ports:
//     clk, rst_in : clock, synchronous active-high reset (clears accumulator)
//     en          : beat accepted this cycle, update accumulator
//     first       : this beat is the first of the job (seed instead of acc)
//     seed_use    : seed with psum when first, else seed with zero
//     a, b        : activation and weight samples (signed)
//     psum        : partial-sum seed (signed)
//     acc_nxt     : accumulator value including the current product
module mac_lane #(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned ACCUMULATION_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_in,
  input  logic                                 en,
  input  logic                                 first,
  input  logic                                 seed_use,
  input  logic signed [IO_DATA_WIDTH-1:0]      a,
  input  logic signed [IO_DATA_WIDTH-1:0]      b,
  input  logic signed [ACCUMULATION_WIDTH-1:0] psum,
  output logic signed [ACCUMULATION_WIDTH-1:0] acc_nxt
);

  logic signed [2*IO_DATA_WIDTH-1:0]      prod;
  logic signed [ACCUMULATION_WIDTH-1:0]   prod_ext;
  logic signed [ACCUMULATION_WIDTH-1:0]   base;
  logic signed [ACCUMULATION_WIDTH-1:0]   acc_q;

  assign prod     = a * b;
  assign prod_ext = ACCUMULATION_WIDTH'(prod);

  always_comb begin
    base = acc_q;
    if (first) begin
      base = seed_use ? psum : '0;
    end
  end

  // Two's-complement wrap is intended; no saturation inside the accumulator.
  assign acc_nxt = base + prod_ext;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// mac_lane_array
//   Broadcast one activation stream to NB_LANES weight lanes, accumulate
//   cfg_acc_len products per lane (optionally seeded by psum_in), then shift,
//   ReLU and saturate, presenting one registered output beat with
//   valid/ready backpressure.
//   Ports:
//     clk, rst_in           : clock, synchronous active-high reset
//     start, busy           : job request / job in progress
//     cfg_acc_len, cfg_out_shift, cfg_relu, cfg_psum_use
//                           : job configuration, latched when a job is taken
//     psum_in, a_in, b_in   : partial sums, activation, per-lane weights
//     in_valid, in_ready    : input beat handshake
//     out_data, out_acc, out_sat
//                           : post-processed samples, raw accumulators, clip flags
//     out_valid, out_ready  : output beat handshake
module mac_lane_array
  import mac_lane_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned ACCUMULATION_WIDTH = 32,
  parameter int unsigned NB_LANES           = 4,
  parameter int unsigned MAX_ACC_LEN        = MAX_ACC_LEN_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_in,
  input  logic                                   start,
  output logic                                   busy,
  input  logic [$clog2(MAX_ACC_LEN+1)-1:0]       cfg_acc_len,
  input  logic [4:0]                             cfg_out_shift,
  input  logic                                   cfg_relu,
  input  logic                                   cfg_psum_use,
  input  logic [NB_LANES*ACCUMULATION_WIDTH-1:0] psum_in,
  input  logic [IO_DATA_WIDTH-1:0]               a_in,
  input  logic [NB_LANES*IO_DATA_WIDTH-1:0]      b_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NB_LANES*IO_DATA_WIDTH-1:0]      out_data,
  output logic [NB_LANES*ACCUMULATION_WIDTH-1:0] out_acc,
  output logic [NB_LANES-1:0]                    out_sat,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int unsigned CNT_W = $clog2(MAX_ACC_LEN + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [4:0]       shift_q;
  logic             relu_q;
  logic             psum_use_q;

  logic accept;
  logic first_beat;
  logic last_beat;
  logic take_job;

  assign accept     = in_valid && in_ready;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == (len_q - CNT_W'(1)));
  assign take_job   = start && (cfg_acc_len != '0);

  logic signed [ACCUMULATION_WIDTH-1:0] lane_nxt  [NB_LANES];
  logic        [IO_DATA_WIDTH-1:0]      lane_data [NB_LANES];
  logic        [NB_LANES-1:0]           lane_sat;

  for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
    sat_res_t                          res;
    logic [CALC_W-IO_DATA_WIDTH-1:0]   data_hi_unused;

    mac_lane #(
      .IO_DATA_WIDTH      (IO_DATA_WIDTH),
      .ACCUMULATION_WIDTH (ACCUMULATION_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_in   (rst_in),
      .en       (accept),
      .first    (first_beat),
      .seed_use (psum_use_q),
      .a        (a_in),
      .b        (b_in[gi*IO_DATA_WIDTH +: IO_DATA_WIDTH]),
      .psum     (psum_in[gi*ACCUMULATION_WIDTH +: ACCUMULATION_WIDTH]),
      .acc_nxt  (lane_nxt[gi])
    );

    // Post-processing reads the next-state accumulator so the output beat
    // includes the last product and is registered on that same edge.
    assign res = sat_shift(CALC_W'(lane_nxt[gi]), shift_q, relu_q, IO_DATA_WIDTH);
    assign lane_sat[gi] = res.sat;
    assign {data_hi_unused, lane_data[gi]} = res.data;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      psum_use_q <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_sat    <= '0;
      out_data   <= '0;
      out_acc    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_job) begin
            len_q      <= cfg_acc_len;
            shift_q    <= cfg_out_shift;
            relu_q     <= cfg_relu;
            psum_use_q <= cfg_psum_use;
            cnt_q      <= '0;
            state_q    <= ACCUM;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              for (int unsigned i = 0; i < NB_LANES; i++) begin
                out_data[i*IO_DATA_WIDTH +: IO_DATA_WIDTH]           <= lane_data[i];
                out_acc[i*ACCUMULATION_WIDTH +: ACCUMULATION_WIDTH] <= lane_nxt[i];
              end
              out_sat   <= lane_sat;
              state_q   <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (take_job) begin
              len_q      <= cfg_acc_len;
              shift_q    <= cfg_out_shift;
              relu_q     <= cfg_relu;
              psum_use_q <= cfg_psum_use;
              cnt_q      <= '0;
              state_q    <= ACCUM;
              in_ready   <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lane_array.sv
module tb_mac_lane_array;

  localparam int IO   = 16;
  localparam int ACC  = 32;
  localparam int NB   = 4;
  localparam int MAXL = 1600;
  localparam int CW   = $clog2(MAXL + 1);

  logic              clk = 1'b0;
  logic              rst_in;
  logic              start;
  logic              busy;
  logic [CW-1:0]     cfg_acc_len;
  logic [4:0]        cfg_out_shift;
  logic              cfg_relu;
  logic              cfg_psum_use;
  logic [NB*ACC-1:0] psum_in;
  logic [IO-1:0]     a_in;
  logic [NB*IO-1:0]  b_in;
  logic              in_valid;
  logic              in_ready;
  logic [NB*IO-1:0]  out_data;
  logic [NB*ACC-1:0] out_acc;
  logic [NB-1:0]     out_sat;
  logic              out_valid;
  logic              out_ready;

  mac_lane_array #(
    .IO_DATA_WIDTH      (IO),
    .ACCUMULATION_WIDTH (ACC),
    .NB_LANES           (NB),
    .MAX_ACC_LEN        (MAXL)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .start         (start),
    .busy          (busy),
    .cfg_acc_len   (cfg_acc_len),
    .cfg_out_shift (cfg_out_shift),
    .cfg_relu      (cfg_relu),
    .cfg_psum_use  (cfg_psum_use),
    .psum_in       (psum_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_acc       (out_acc),
    .out_sat       (out_sat),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Current job description and its operands.
  int a_arr [MAXL];
  int b_arr [MAXL][NB];
  int ps_arr [NB];
  int cur_len, cur_sh, cur_relu, cur_pu;

  longint exp_data [NB];
  longint exp_acc  [NB];
  int     exp_sat  [NB];

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: integer sum of products, wrapped to ACC bits, floor-divided by
  // 2^shift, then ReLU and clip to the IO sample range.
  task automatic build_expect();
    longint acc, p, s, hi, lo;
    hi = (longint'(1) << (IO - 1)) - 1;
    lo = -(longint'(1) << (IO - 1));
    for (int l = 0; l < NB; l++) begin
      acc = cur_pu ? longint'(ps_arr[l]) : 0;
      for (int k = 0; k < cur_len; k++)
        acc += longint'(a_arr[k]) * longint'(b_arr[k][l]);
      acc = acc & ((longint'(1) << ACC) - 1);
      if (acc >= (longint'(1) << (ACC - 1))) acc -= (longint'(1) << ACC);
      exp_acc[l] = acc;
      p = longint'(1) << cur_sh;
      if (acc >= 0) s = acc / p;
      else          s = -((-acc + p - 1) / p);
      exp_sat[l] = 0;
      if (cur_relu != 0 && s < 0) s = 0;
      else if (s > hi) begin s = hi; exp_sat[l] = 1; end
      else if (s < lo) begin s = lo; exp_sat[l] = 1; end
      exp_data[l] = s;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int l = 0; l < NB; l++) begin
      check({tag, "_data"}, $signed(out_data[l*IO +: IO]), exp_data[l]);
      check({tag, "_acc"},  $signed(out_acc[l*ACC +: ACC]), exp_acc[l]);
      check({tag, "_sat"},  out_sat[l], exp_sat[l]);
    end
  endtask

  task automatic rand_ops(input int len);
    for (int k = 0; k < len; k++) begin
      a_arr[k] = int'($urandom_range(0, 65535)) - 32768;
      for (int l = 0; l < NB; l++) b_arr[k][l] = int'($urandom_range(0, 65535)) - 32768;
    end
    for (int l = 0; l < NB; l++) ps_arr[l] = int'($urandom);
  endtask

  task automatic drive_cfg(input int len, input int sh, input int relu, input int pu);
    cfg_acc_len   = CW'(len);
    cfg_out_shift = 5'(sh);
    cfg_relu      = 1'(relu);
    cfg_psum_use  = 1'(pu);
  endtask

  // Config changes after latching must not matter.
  task automatic scramble_cfg();
    drive_cfg($urandom_range(1, MAXL), $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic launch(input int len, input int sh, input int relu, input int pu);
    start = 1'b1;
    drive_cfg(len, sh, relu, pu);
    @(negedge clk);
    start = 1'b0;
    cur_len = len; cur_sh = sh; cur_relu = relu; cur_pu = pu;
    scramble_cfg();
    check("launch_busy", busy, 1);
    check("launch_in_ready", in_ready, 1);
  endtask

  // Feed nbeats beats; gaps before every beat after the first are either
  // fixed_gap cycles or random up to max_gap cycles.
  task automatic feed(input int nbeats, input int max_gap, input int fixed_gap);
    int g, t;
    for (int k = 0; k < nbeats; k++) begin
      g = (k == 0) ? 0 : (fixed_gap > 0 ? fixed_gap : (max_gap > 0 ? $urandom_range(0, max_gap) : 0));
      repeat (g) begin
        in_valid = 1'b0;
        a_in     = IO'($urandom);
        b_in     = {NB{IO'($urandom)}};
        psum_in  = {NB{ACC'($urandom)}};
        @(negedge clk);
      end
      in_valid = 1'b1;
      a_in     = IO'(a_arr[k]);
      for (int l = 0; l < NB; l++) begin
        b_in[l*IO +: IO] = IO'(b_arr[k][l]);
        psum_in[l*ACC +: ACC] = (k == 0) ? ACC'(ps_arr[l]) : ACC'($urandom);
      end
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) check("in_ready_timeout", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Output beat: check it, hold backpressure, then handshake (optionally
  // with a back-to-back start).
  task automatic drain(input int hold, input int chain,
                       input int nlen, input int nsh, input int nrelu, input int npu);
    build_expect();
    check("out_valid_latency", out_valid, 1);
    check("out_busy", busy, 1);
    check_outputs("out");
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      for (int l = 0; l < NB; l++)
        check("hold_data", $signed(out_data[l*IO +: IO]), exp_data[l]);
    end
    out_ready = 1'b1;
    if (chain != 0) begin
      start = 1'b1;
      drive_cfg(nlen, nsh, nrelu, npu);
    end
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("post_hs_valid", out_valid, 0);
    if (chain != 0) begin
      cur_len = nlen; cur_sh = nsh; cur_relu = nrelu; cur_pu = npu;
      scramble_cfg();
      check("chain_busy", busy, 1);
      check("chain_in_ready", in_ready, 1);
    end else begin
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sat"}, out_sat, 0);
    check({tag, "_out_data"}, (out_data == '0) ? 0 : 1, 0);
    check({tag, "_out_acc"}, (out_acc == '0) ? 0 : 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; psum_in = '0;
    drive_cfg(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_in = 1'b0;
    @(negedge clk);

    // Basic job.
    a_arr[0] = 2; a_arr[1] = 3; a_arr[2] = 4;
    for (int k = 0; k < 3; k++) begin
      b_arr[k][0] = 1; b_arr[k][1] = -1; b_arr[k][2] = 0; b_arr[k][3] = 5;
    end
    for (int l = 0; l < NB; l++) ps_arr[l] = 777;
    launch(3, 0, 0, 0);
    feed(3, 0, 0);
    check("basic_lane0_const", $signed(out_data[0 +: IO]), 9);
    check("basic_lane1_const", $signed(out_data[IO +: IO]), -9);
    drain(0, 0, 0, 0, 0, 0);

    // Partial-sum seed.
    a_arr[0] = 5;
    for (int l = 0; l < NB; l++) begin b_arr[0][l] = 6; ps_arr[l] = 100 * (l + 1); end
    launch(1, 0, 0, 1);
    feed(1, 0, 0);
    check("psum_lane0_const", $signed(out_acc[0 +: ACC]), 130);
    drain(0, 0, 0, 0, 0, 0);

    // Saturation, ReLU, shift.
    a_arr[0] = 32767;
    for (int l = 0; l < NB; l++) b_arr[0][l] = 32767;
    launch(1, 0, 0, 0);
    feed(1, 0, 0);
    check("sat_pos_const", $signed(out_data[0 +: IO]), 32767);
    check("sat_pos_flag", out_sat[0], 1);
    drain(0, 0, 0, 0, 0, 0);
    for (int l = 0; l < NB; l++) b_arr[0][l] = -32767;
    launch(1, 0, 1, 0);
    feed(1, 0, 0);
    check("relu_neg_const", $signed(out_data[0 +: IO]), 0);
    drain(0, 0, 0, 0, 0, 0);
    for (int l = 0; l < NB; l++) b_arr[0][l] = 32767;
    launch(1, 15, 0, 0);
    feed(1, 0, 0);
    check("shift15_const", $signed(out_data[0 +: IO]), 32766);
    drain(0, 0, 0, 0, 0, 0);

    // Backpressure then back-to-back job with len=2.
    rand_ops(4);
    launch(4, 3, 0, 1);
    feed(4, 0, 0);
    drain(5, 1, 2, 2, 1, 0);
    rand_ops(2);
    feed(2, 0, 0);
    drain(0, 0, 0, 0, 0, 0);

    // Stalls: in_valid 1,0,0,1.
    rand_ops(2);
    launch(2, 4, 0, 1);
    feed(2, 0, 2);
    drain(0, 0, 0, 0, 0, 0);

    // Zero length start is ignored.
    start = 1'b1;
    drive_cfg(0, 1, 1, 1);
    @(negedge clk);
    start = 1'b0;
    check("zero_len_busy", busy, 0);
    check("zero_len_in_ready", in_ready, 0);
    @(negedge clk);
    check("zero_len_busy2", busy, 0);

    // Mid-job reset, then a clean job.
    rand_ops(4);
    launch(4, 0, 0, 1);
    feed(2, 0, 0);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check_all_zero("midreset");
    @(negedge clk);
    check("midreset_valid2", out_valid, 0);
    rand_ops(3);
    launch(3, 1, 0, 0);
    feed(3, 0, 0);
    drain(0, 0, 0, 0, 0, 0);

    // Longest job.
    rand_ops(MAXL);
    launch(MAXL, 20, 0, 1);
    feed(MAXL, 0, 0);
    drain(1, 0, 0, 0, 0, 0);

    // Random jobs, some chained back-to-back.
    begin
      int chain, len, nlen;
      chain = 0;
      nlen = 0;
      for (int j = 0; j < 30; j++) begin
        if (chain != 0) len = nlen;
        else len = $urandom_range(1, 24);
        rand_ops(len);
        if (chain == 0)
          launch(len, $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1));
        feed(len, 2, 0);
        chain = (j < 29) ? $urandom_range(0, 1) : 0;
        nlen  = $urandom_range(1, 24);
        drain($urandom_range(0, 3), chain, nlen, $urandom_range(0, 31),
              $urandom_range(0, 1), $urandom_range(0, 1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
